// File: rtl/galaksija_load_arbiter.sv
// Galaksija memory arbiter: merges ioctl download writes (buffered in a small
// FIFO) with CPU accesses onto a single request/acknowledge memory port.
// Download writes always win over the CPU. The optional post-load CPU reset
// pulse is built only when GALAKSIJA_POSTLOAD_RESET_EN is defined.
module galaksija_load_arbiter #(
    parameter logic [15:0] ROM_BASE   = 16'h0000,
    parameter logic [15:0] TAPE_BASE  = 16'h2000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    // CPU port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_wait,
    // Loader port
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    // Memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    // Status
    output logic        fifo_overflow,
    output logic        cpu_reset
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DL_ACC  = 2'd1;
    localparam logic [1:0] CPU_ACC = 2'd2;

    logic [1:0]       state;
    logic [15:0]      fifo_addr [FIFO_DEPTH];
    logic [7:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             dl_q;
    logic             cpu_abort;

    logic             dl_rise;
    logic             strobe;
    logic [15:0]      strobe_addr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             overflow_evt;
    logic             cpu_grant;

    // Strobe qualification, FIFO flags and arbitration decisions
    always_comb begin
        dl_rise      = ioctl_download && !dl_q;
        strobe       = ioctl_download && ioctl_wr && (ioctl_index[7:1] == 7'd0);
        strobe_addr  = (ioctl_index[0] ? TAPE_BASE : ROM_BASE) + ioctl_addr;
        fifo_empty   = (count == '0);
        fifo_full    = (count == DEPTH_C);
        pop          = (state == IDLE) && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push         = strobe && (!fifo_full || pop);
        overflow_evt = strobe && fifo_full && !pop;
        cpu_wait     = ioctl_download || !fifo_empty || (state != IDLE);
        // cpu_ack high means the CPU is still holding the request it just had
        // completed; do not grant it a second time.
        cpu_grant    = (state == IDLE) && cpu_req && !cpu_wait && !cpu_ack;
    end

    // FIFO storage (no reset needed, occupancy is tracked by count)
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= strobe_addr;
            fifo_data[wr_ptr] <= ioctl_dout;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Download edge tracking and sticky overflow flag
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q          <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise)
                fifo_overflow <= 1'b0;
            if (overflow_evt)
                fifo_overflow <= 1'b1;
        end
    end

    // Arbitration FSM with registered memory port
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cpu_dout  <= '0;
            cpu_ack   <= 1'b0;
            cpu_abort <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= DL_ACC;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= fifo_addr[rd_ptr];
                        mem_din  <= fifo_data[rd_ptr];
                    end else if (cpu_grant) begin
                        state     <= CPU_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_din   <= cpu_din;
                        cpu_abort <= 1'b0;
                    end
                end
                DL_ACC: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                CPU_ACC: begin
                    // A dropped request is finished on the bus but never acked.
                    if (!cpu_req)
                        cpu_abort <= 1'b1;
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we)
                            cpu_dout <= mem_dout;
                        cpu_ack <= cpu_req && !cpu_abort;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GALAKSIJA_POSTLOAD_RESET_EN
    logic       dl_fall;
    logic       load_pend;
    logic [4:0] rst_cnt;

    assign dl_fall   = !ioctl_download && dl_q;
    assign cpu_reset = (rst_cnt != '0);

    // Post-load reset: arm on download end, fire 16 cycles once FIFO drained
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            load_pend <= 1'b0;
            rst_cnt   <= '0;
        end else if (dl_rise) begin
            load_pend <= 1'b0;
            rst_cnt   <= '0;
        end else if ((dl_fall || load_pend) && fifo_empty) begin
            load_pend <= 1'b0;
            rst_cnt   <= 5'd16;
        end else begin
            if (dl_fall)
                load_pend <= 1'b1;
            if (rst_cnt != '0)
                rst_cnt <= rst_cnt - 5'd1;
        end
    end
`else
    assign cpu_reset = 1'b0;
`endif

endmodule
